// File: rtl/mem_stage_reg_if.sv
// rtl/mem_stage_reg_if.sv - EXE/MEM inputs and MEM/WB outputs of the MEM stage
// mem_fault exists only when MEM_RANGE_CHECK_EN is defined.
interface mem_stage_reg_if #(
    parameter int N = 32
);
    logic         freeze;
    logic         WB_ENIn;
    logic         MEM_R_ENIn;
    logic         MEM_W_ENIn;
    logic [N-1:0] ALU_ResIn;
    logic [N-1:0] Val_RmIn;
    logic [3:0]   WB_DestIn;
    logic         WB_ENOut;
    logic         MEM_R_ENOut;
    logic [N-1:0] ALU_ResOut;
    logic [N-1:0] DataMemoryOut;
    logic [3:0]   WB_DestOut;
`ifdef MEM_RANGE_CHECK_EN
    logic         mem_fault;
`endif

    modport master (
        output freeze, WB_ENIn, MEM_R_ENIn, MEM_W_ENIn, ALU_ResIn, Val_RmIn, WB_DestIn,
`ifdef MEM_RANGE_CHECK_EN
        input  mem_fault,
`endif
        input  WB_ENOut, MEM_R_ENOut, ALU_ResOut, DataMemoryOut, WB_DestOut
    );

    modport slave (
        input  freeze, WB_ENIn, MEM_R_ENIn, MEM_W_ENIn, ALU_ResIn, Val_RmIn, WB_DestIn,
`ifdef MEM_RANGE_CHECK_EN
        output mem_fault,
`endif
        output WB_ENOut, MEM_R_ENOut, ALU_ResOut, DataMemoryOut, WB_DestOut
    );
endinterface

// File: rtl/mem_stage_reg.sv
// rtl/mem_stage_reg.sv - MEM stage data memory plus MEM/WB pipeline register
// Optional MEM_RANGE_CHECK_EN: suppress out-of-range stores, zero out-of-range loads, report mem_fault.
module mem_stage_reg #(
    parameter int N         = 32,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 1024
) (
    input  logic              clk,
    input  logic              rst,
    mem_stage_reg_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  addr_off;
    logic [AW-1:0] idx;
    logic          mem_we;
    logic [N-1:0]  rd_word;

    logic          wb_en_q,   wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic [N-1:0]  alu_res_q, alu_res_d;
    logic [N-1:0]  dmem_q,    dmem_d;
    logic [3:0]    wb_dest_q, wb_dest_d;
`ifdef MEM_RANGE_CHECK_EN
    logic          fault_q,   fault_d;
    logic          in_range;
`endif

    // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
    always_comb begin
        addr_off = bus.ALU_ResIn - N'(BASE_ADDR);
        idx      = AW'(addr_off >> 2);
        rd_word  = mem_q[idx];
        mem_we   = ~bus.freeze & bus.MEM_W_ENIn;
`ifdef MEM_RANGE_CHECK_EN
        in_range = addr_off < N'(4 * DEPTH);
        mem_we   = mem_we & in_range;
        if (!in_range) begin
            rd_word = '0;
        end
`endif
    end

    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_res_d  = alu_res_q;
        dmem_d     = dmem_q;
        wb_dest_d  = wb_dest_q;
`ifdef MEM_RANGE_CHECK_EN
        fault_d    = fault_q;
`endif
        if (!bus.freeze) begin
            wb_en_d    = bus.WB_ENIn;
            mem_r_en_d = bus.MEM_R_ENIn;
            alu_res_d  = bus.ALU_ResIn;
            dmem_d     = rd_word;
            wb_dest_d  = bus.WB_DestIn;
`ifdef MEM_RANGE_CHECK_EN
            fault_d    = (bus.MEM_R_ENIn | bus.MEM_W_ENIn) & ~in_range;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            dmem_q     <= '0;
            wb_dest_q  <= '0;
`ifdef MEM_RANGE_CHECK_EN
            fault_q    <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_res_q  <= alu_res_d;
            dmem_q     <= dmem_d;
            wb_dest_q  <= wb_dest_d;
`ifdef MEM_RANGE_CHECK_EN
            fault_q    <= fault_d;
`endif
            if (mem_we) begin
                mem_q[idx] <= bus.Val_RmIn;
            end
        end
    end

    assign bus.WB_ENOut      = wb_en_q;
    assign bus.MEM_R_ENOut   = mem_r_en_q;
    assign bus.ALU_ResOut    = alu_res_q;
    assign bus.DataMemoryOut = dmem_q;
    assign bus.WB_DestOut    = wb_dest_q;
`ifdef MEM_RANGE_CHECK_EN
    assign bus.mem_fault     = fault_q;
`endif
endmodule

// File: tb/tb_mem_stage_reg.sv
// tb/tb_mem_stage_reg.sv - directed self-checking bench for mem_stage_reg
module tb_mem_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_stage_reg_if #(.N(32)) bus ();

    mem_stage_reg #(.N(32), .DEPTH(64), .BASE_ADDR(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wb, input logic rd, input logic wr,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
        bus.WB_ENIn    = wb;
        bus.MEM_R_ENIn = rd;
        bus.MEM_W_ENIn = wr;
        bus.ALU_ResIn  = alu;
        bus.Val_RmIn   = val;
        bus.WB_DestIn  = dest;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic wb, input logic rd,
                            input logic [31:0] alu, input logic [31:0] data, input logic [3:0] dest);
        chk({tag, ".wb_en"},   {31'b0, bus.WB_ENOut},    {31'b0, wb});
        chk({tag, ".mem_r"},   {31'b0, bus.MEM_R_ENOut}, {31'b0, rd});
        chk({tag, ".alu"},     bus.ALU_ResOut,           alu);
        chk({tag, ".data"},    bus.DataMemoryOut,        data);
        chk({tag, ".dest"},    {28'b0, bus.WB_DestOut},  {28'b0, dest});
    endtask

    initial begin
        bus.freeze = 1'b0;
        // Reset has priority over an attempted store to 1028.
        rst = 1'b0;
        drive(1, 1, 1, 32'd1028, 32'hFFFF, 4'h5);
        step();
        step();
        chk_outs("reset", 0, 0, 32'd0, 32'd0, 4'h0);
        rst = 1'b1;

        drive(0, 1, 0, 32'd1024, 32'd0, 4'h0);
        step();
        chk_outs("ld_1024_after_reset", 0, 1, 32'd1024, 32'd0, 4'h0);

        drive(1, 0, 1, 32'd1028, 32'hDEADBEEF, 4'h2);
        step();
        chk_outs("str_1028", 1, 0, 32'd1028, 32'd0, 4'h2);

        drive(1, 1, 0, 32'd1028, 32'd0, 4'h2);
        step();
        chk_outs("ldr_1028", 1, 1, 32'd1028, 32'hDEADBEEF, 4'h2);

        drive(1, 0, 0, 32'h55, 32'd0, 4'hA);
        step();
        chk({"pass.wb_en"}, {31'b0, bus.WB_ENOut}, 32'd1);
        chk({"pass.dest"},  {28'b0, bus.WB_DestOut}, 32'hA);
        chk({"pass.alu"},   bus.ALU_ResOut, 32'h55);
        chk({"pass.mem_r"}, {31'b0, bus.MEM_R_ENOut}, 32'd0);

        drive(1, 1, 1, 32'd1028, 32'h12345678, 4'h7);
        step();
        chk_outs("rw_same_cycle", 1, 1, 32'd1028, 32'hDEADBEEF, 4'h7);

        drive(0, 1, 0, 32'd1028, 32'd0, 4'h6);
        step();
        chk_outs("ld_after_rw", 0, 1, 32'd1028, 32'h12345678, 4'h6);

        bus.freeze = 1'b1;
        drive(1, 0, 1, 32'd1032, 32'h1, 4'h3);
        step();
        chk_outs("freeze_hold", 0, 1, 32'd1028, 32'h12345678, 4'h6);
        bus.freeze = 1'b0;

        drive(1, 1, 0, 32'd1032, 32'd0, 4'h3);
        step();
        chk_outs("ld_1032_after_freeze", 1, 1, 32'd1032, 32'd0, 4'h3);

        drive(0, 0, 1, 32'd1280, 32'h77, 4'h0);
        step();
`ifdef MEM_RANGE_CHECK_EN
        chk("oor_store.fault", {31'b0, bus.mem_fault}, 32'd1);
`endif
        drive(0, 1, 0, 32'd1024, 32'd0, 4'h0);
        step();
`ifdef MEM_RANGE_CHECK_EN
        chk("ld_1024_after_oor.data", bus.DataMemoryOut, 32'd0);
        chk("ld_1024_after_oor.fault", {31'b0, bus.mem_fault}, 32'd0);
`else
        chk("wrap_ld_1024.data", bus.DataMemoryOut, 32'h77);
`endif

        drive(0, 0, 1, 32'd1030, 32'hAB, 4'h0);
        step();
        drive(0, 1, 0, 32'd1028, 32'd0, 4'h0);
        step();
        chk("subword_ld_1028", bus.DataMemoryOut, 32'hAB);

        // Reset mid-store: the store is discarded and memory is cleared.
        rst = 1'b0;
        drive(1, 0, 1, 32'd1036, 32'h99, 4'h9);
        step();
        chk_outs("reset_mid_store", 0, 0, 32'd0, 32'd0, 4'h0);
        rst = 1'b1;
        drive(0, 1, 0, 32'd1036, 32'd0, 4'h0);
        step();
        chk("ld_1036_after_reset", bus.DataMemoryOut, 32'd0);
        drive(0, 1, 0, 32'd1028, 32'd0, 4'h0);
        step();
        chk("ld_1028_after_reset", bus.DataMemoryOut, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
